// File: rtl/ser_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ser_tx_pkg
//  Brief    : Shared constants and FSM encoding for the serial dataset link
//             (used by both the transmitter and the receiver side).
//  Revision : 1.0 - initial release
// ============================================================================
package ser_tx_pkg;

    localparam int LENGTH       = 16;   // bits per word
    localparam int ADDR_WIDTH   = 12;   // point index width
    localparam int MAX_FEATURES = 15;   // highest legal feat value
    localparam int FEAT_W       = 4;    // word index width
    localparam int BIT_W        = $clog2(LENGTH);
    localparam int STATE_W      = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_LOAD  = 3'd2;
    localparam state_t ST_SHIFT = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/ser_piso.sv
`default_nettype none
// ============================================================================
//  Module   : ser_piso
//  Brief    : LENGTH-bit parallel-load shift register, LSB out, with a
//             next-word buffer so consecutive words stream without a gap.
//  Revision : 1.0 - initial release
// ============================================================================
module ser_piso
    import ser_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,      // shift reg <= i_data
    input  logic              i_cap_next,  // next-word buffer <= i_data
    input  logic              i_swap,      // shift reg <= next-word buffer
    input  logic              i_shift,     // shift right one bit
    input  logic [LENGTH-1:0] i_data,
    output logic              o_bit
);

    logic [LENGTH-1:0] r_shift;
    logic [LENGTH-1:0] r_next;

    // Shift register with load/swap taking priority over a plain shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
        end else if (i_swap) begin
            r_shift <= r_next;
        end else if (i_shift) begin
            r_shift <= {1'b0, r_shift[LENGTH-1:1]};
        end
    end

    // Next-word buffer filled by the prefetch read while the current word shifts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next <= '0;
        end else if (i_cap_next) begin
            r_next <= i_data;
        end
    end

    assign o_bit = r_shift[0];

endmodule
`default_nettype wire

// File: rtl/ser_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ser_tx
//  Brief    : Serial frame transmitter. Streams (data_points+1) points of
//             (feat+1) words each, highest word first within a point, LSB
//             first, one bit per clock, with no gap between words.
//  Revision : 1.0 - initial release
// ============================================================================
module ser_tx
    import ser_tx_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic [FEAT_W-1:0]     feat,
    input  logic [ADDR_WIDTH-1:0] data_points,
    output logic [ADDR_WIDTH-1:0] rd_pt,
    output logic [FEAT_W-1:0]     rd_feat,
    input  logic [LENGTH-1:0]     rd_data,
    output logic                  S,
    output logic                  S_valid,
    output logic                  busy,
    output logic                  done_
);

    // Bit-counter milestones inside one word:
    //   c_bit_pf   : edge where the next address is registered (counter -> LENGTH-3)
    //   c_bit_cap  : edge where the read data lands in the next-word buffer
    //   c_bit_last : edge where the next word moves into the shift register
    localparam logic [BIT_W-1:0] c_bit_pf   = BIT_W'(LENGTH - 4);
    localparam logic [BIT_W-1:0] c_bit_cap  = BIT_W'(LENGTH - 2);
    localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(LENGTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [FEAT_W-1:0]     r_feat_lat;
    logic [ADDR_WIDTH-1:0] r_dp_lat;
    logic [BIT_W-1:0]      r_bit;
    logic                  r_is_last;   // word currently shifting is the final one

    logic w_accept;
    logic w_in_shift;
    logic w_bit_end;
    logic w_prefetch;
    logic w_on_last;
    logic w_piso_bit;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_in_shift = (r_state == ST_SHIFT);
    assign w_bit_end  = w_in_shift && (r_bit == c_bit_last);
    assign w_prefetch = w_in_shift && (r_bit == c_bit_pf);
    // Compared before any increment so the top point index never overflows
    assign w_on_last  = (rd_pt == r_dp_lat) && (rd_feat == '0);

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_FETCH;
            ST_FETCH: w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_bit_end && r_is_last) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; S is forced low outside a frame bit
    always_comb begin
        S       = 1'b0;
        S_valid = 1'b0;
        busy    = 1'b0;
        done_   = 1'b0;
        case (r_state)
            ST_FETCH, ST_LOAD: busy = 1'b1;
            ST_SHIFT: begin
                S       = w_piso_bit;
                S_valid = 1'b1;
                busy    = 1'b1;
            end
            ST_DONE:  done_ = 1'b1;
            default:  ;
        endcase
    end

    // Frame parameters latch, bit counter and read-address walk (point up, word down)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_pt      <= '0;
            rd_feat    <= '0;
            r_feat_lat <= '0;
            r_dp_lat   <= '0;
            r_bit      <= '0;
            r_is_last  <= 1'b0;
        end else if (w_accept) begin
            rd_pt      <= '0;
            rd_feat    <= feat;
            r_feat_lat <= feat;
            r_dp_lat   <= data_points;
            r_bit      <= '0;
            r_is_last  <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            r_bit <= '0;
        end else if (w_in_shift) begin
            r_bit <= w_bit_end ? '0 : r_bit + BIT_W'(1);
            if (w_prefetch) begin
                if (w_on_last) begin
                    r_is_last <= 1'b1;
                end else if (rd_feat != '0) begin
                    rd_feat <= rd_feat - FEAT_W'(1);
                end else begin
                    rd_feat <= r_feat_lat;
                    rd_pt   <= rd_pt + ADDR_WIDTH'(1);
                end
            end
        end
    end

    ser_piso u_piso (
        .clk        (CLK),
        .rst_n      (RST_N),
        .i_load     (r_state == ST_LOAD),
        .i_cap_next (w_in_shift && (r_bit == c_bit_cap) && !r_is_last),
        .i_swap     (w_bit_end && !r_is_last),
        .i_shift    (w_in_shift),
        .i_data     (rd_data),
        .o_bit      (w_piso_bit)
    );

endmodule
`default_nettype wire

// File: tb/tb_ser_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ser_tx
//  Brief    : Scoreboard bench for ser_tx. The stimulus side queues the words
//             a frame must carry; a monitor deserialises S and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ser_tx;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        start;
    logic [3:0]  feat;
    logic [11:0] data_points;
    logic [11:0] rd_pt;
    logic [3:0]  rd_feat;
    logic [15:0] rd_data = 16'h0;
    logic        S, S_valid, busy, done_;

    ser_tx dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start),
        .feat        (feat),
        .data_points (data_points),
        .rd_pt       (rd_pt),
        .rd_feat     (rd_feat),
        .rd_data     (rd_data),
        .S           (S),
        .S_valid     (S_valid),
        .busy        (busy),
        .done_       (done_)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous-read word memory
    logic [15:0] mem [0:4095][0:15];
    always @(posedge CLK) rd_data <= mem[rd_pt][rd_feat];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard state shared by stimulus and monitor
    logic [15:0] exp_q[$];
    int          exp_bits  = 0;
    int          start_cyc = 0;
    int          done_cnt  = 0;

    // Monitor: deserialise S and compare against the queued words
    logic [15:0] acc = 16'h0;
    int          nbit = 0, vcnt = 0, first_v = 0, last_v = 0;
    always @(negedge CLK) begin
        logic [15:0] e;
        if (!RST_N) begin
            acc = 16'h0; nbit = 0; vcnt = 0;
        end else begin
            if (!S_valid) chk("s_low_outside_frame", S, 0);
            if (S_valid) begin
                if (vcnt == 0) begin
                    first_v = cyc;
                    chk("first_bit_latency", cyc - start_cyc, 3);
                end
                last_v = cyc;
                vcnt++;
                chk("busy_during_frame", busy, 1);
                acc = {S, acc[15:1]};
                nbit++;
                if (nbit == 16) begin
                    nbit = 0;
                    chk("word_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("word_data", acc, e);
                    end
                end
            end
            if (done_) begin
                chk("frame_bits", vcnt, exp_bits);
                chk("gap_free", last_v - first_v + 1, vcnt);
                chk("done_after_last_bit", cyc, last_v + 1);
                chk("busy_low_at_done", busy, 0);
                vcnt = 0; nbit = 0;
                done_cnt++;
            end
        end
    end

    // mode: 0 plain, 1 spurious starts, 2 inputs changed mid-frame, 3 reset abort
    task automatic run_frame(input int f, input int dp, input int mode);
        int prev, cur, bound, abort_at;
        bit aborted;
        // Reference: points ascending, words descending, values straight from memory
        for (int i = 0; i <= dp; i++)
            for (int j = f; j >= 0; j--)
                exp_q.push_back(mem[i][j]);
        @(negedge CLK);
        exp_bits    = (dp + 1) * (f + 1) * 16;
        feat        = 4'(f);
        data_points = 12'(dp);
        start       = 1'b1;
        start_cyc   = cyc;
        prev        = done_cnt;
        bound       = exp_bits + 40;
        abort_at    = 3 + 3 * (f + 1) * 16 + 5;
        aborted     = 1'b0;
        for (int t = 0; t < bound; t++) begin
            @(negedge CLK);
            cur   = cyc - start_cyc;
            start = 1'b0;
            if (mode == 1 && (cur == 3 + 16 + 7 || cur == 3 + exp_bits)) start = 1'b1;
            if (mode == 2 && cur == 40) begin
                feat        = 4'($urandom);
                data_points = 12'($urandom);
            end
            if (mode == 3 && cur == abort_at) begin
                RST_N = 1'b0;
                #1;
                chk("abort_s", S, 0);
                chk("abort_s_valid", S_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_rd_pt", rd_pt, 0);
                aborted = 1'b1;
                break;
            end
            if (done_cnt != prev) break;
        end
        if (aborted) begin
            @(negedge CLK);
            @(negedge CLK);
            exp_q.delete();
            RST_N = 1'b1;
            chk("no_done_on_abort", done_cnt, prev);
        end else begin
            @(negedge CLK);
            start = 1'b0;
            chk("frame_completed", done_cnt != prev, 1);
            repeat (3) @(negedge CLK);
            chk("single_done", done_cnt, prev + 1);
            chk("idle_after_done", busy, 0);
            chk("queue_drained", exp_q.size(), 0);
        end
    endtask

    initial begin
        RST_N = 1'b0; start = 1'b0; feat = 4'd0; data_points = 12'd0;
        for (int i = 0; i < 4096; i++)
            for (int j = 0; j < 16; j++)
                mem[i][j] = 16'($urandom);
        repeat (3) @(negedge CLK);
        chk("rst_s", S, 0);
        chk("rst_s_valid", S_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_, 0);
        chk("rst_rd_pt", rd_pt, 0);
        chk("rst_rd_feat", rd_feat, 0);
        RST_N = 1'b1;

        // Single word, known pattern
        mem[0][0] = 16'hA5C3;
        run_frame(0, 0, 0);

        // Distinct words reveal the read order
        mem[0][2] = 16'h0001; mem[0][1] = 16'h0002; mem[0][0] = 16'h0003;
        mem[1][2] = 16'h0004; mem[1][1] = 16'h0005; mem[1][0] = 16'h0006;
        run_frame(2, 1, 0);

        // Long frame with random memory
        run_frame(14, 120, 0);

        // Starts while busy and in DONE are ignored
        run_frame(3, 4, 1);

        // Reset mid-frame at point 3, then a clean restart
        run_frame(3, 5, 3);
        run_frame(3, 5, 0);

        // Inputs changed during the frame
        run_frame(5, 10, 2);

        // Random shapes, including the widest word count
        for (int k = 0; k < 6; k++)
            run_frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 6)), 0);
        run_frame(15, 3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
